// File: rtl/reg_cmd_ctrl_if.sv
// Register-command bus: byte command stream in, register file port, read response out.
// CmdErr is present only when REG_CMD_ERR_EN is defined.
interface reg_cmd_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
);
  logic [7:0]       InData;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] WrData;
  logic [ADDR-1:0]  Address;
  logic             WrEn;
  logic             RdEn;
  logic [WIDTH-1:0] RdData;
  logic [WIDTH-1:0] RspData;
  logic             RspValid;
  logic             RspReady;
`ifdef REG_CMD_ERR_EN
  logic             CmdErr;
`endif

  modport slave (
    input  InData, InValid, RdData, RspReady,
    output InReady, WrData, Address, WrEn, RdEn,
    output RspData, RspValid
`ifdef REG_CMD_ERR_EN
    , output CmdErr
`endif
  );

  modport master (
    output InData, InValid, RdData, RspReady,
    input  InReady, WrData, Address, WrEn, RdEn,
    input  RspData, RspValid
`ifdef REG_CMD_ERR_EN
    , input CmdErr
`endif
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream write/read command parser driving a register file port.
// Define REG_CMD_ERR_EN to get a CmdErr pulse on unknown command bytes.
module reg_cmd_ctrl #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
) (
  input  logic           CLK,
  input  logic           RST,
  reg_cmd_ctrl_if.slave  bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    CAPTURE,
    RESP
  } state_t;

  state_t           state;
  state_t           next;
  logic             in_ready;
  logic             wr_en;
  logic             rd_en;
  logic             rsp_valid;
  logic             accept;
  logic             hdr_wr;
  logic             hdr_rd;
  logic             is_wr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] wdata;
  logic [ADDR-1:0]  addr;
  logic [WIDTH-1:0] rsp;

  assign hdr_wr = (bus.InData == 8'hA5);
  assign hdr_rd = (bus.InData == 8'h5A);
  assign accept = bus.InValid && in_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.InValid && (hdr_wr || hdr_rd))
          next = GET_ADDR;
      end
      GET_ADDR: begin
        in_ready = 1'b1;
        if (bus.InValid)
          next = is_wr ? GET_DATA : READ;
      end
      GET_DATA: begin
        in_ready = 1'b1;
        if (bus.InValid && cnt == LAST)
          next = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        next  = IDLE;
      end
      READ: begin
        rd_en = 1'b1;
        next  = CAPTURE;
      end
      CAPTURE: next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.RspReady) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      is_wr <= 1'b0;
      cnt   <= '0;
      wdata <= '0;
      addr  <= '0;
      rsp   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE && accept): is_wr <= hdr_wr;
        (state == GET_ADDR && accept): begin
          addr <= bus.InData[ADDR-1:0];
          cnt  <= '0;
        end
        (state == GET_DATA && accept): begin
          for (int i = 0; i < NBYTES; i++)
            if (cnt == CW'(i)) wdata[8*i +: 8] <= bus.InData;
          cnt <= cnt + 1'b1;
        end
        (state == CAPTURE): rsp <= bus.RdData;
        default: ;
      endcase
    end
  end

`ifdef REG_CMD_ERR_EN
  logic err;

  // One-cycle flag for a dropped, unrecognised command byte
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err <= 1'b0;
    else      err <= (state == IDLE) && accept && !hdr_wr && !hdr_rd;
  end

  assign bus.CmdErr = err;
`endif

  assign bus.InReady  = in_ready;
  assign bus.WrEn     = wr_en;
  assign bus.RdEn     = rd_en;
  assign bus.RspValid = rsp_valid;
  assign bus.WrData   = wdata;
  assign bus.Address  = addr;
  assign bus.RspData  = rsp;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl with a small register file model.
// Covers write, read, stalls, gaps, reset mid-frame and unknown bytes.
module tb_reg_cmd_ctrl;
  localparam int WIDTH = 16;
  localparam int ADDR  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   both   = 0;

  reg_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  reg_cmd_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [WIDTH-1:0] mem [2**ADDR];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2**ADDR; i++) mem[i] <= '0;
      bus.RdData <= '0;
    end else begin
      if (bus.WrEn) mem[bus.Address] <= bus.WrData;
      if (bus.RdEn) bus.RdData <= mem[bus.Address];
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      if (bus.WrEn) wr_cnt++;
      if (bus.RdEn) rd_cnt++;
      if (bus.WrEn && bus.RdEn) both++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.InData  = b;
    bus.InValid = 1'b1;
    while (!bus.InReady && n < 50) begin
      step();
      n++;
    end
    check("in_ready", 32'(bus.InReady), 32'd1);
    step();
    bus.InValid = 1'b0;
  endtask

  initial begin
    bus.InData   = 8'h00;
    bus.InValid  = 1'b0;
    bus.RspReady = 1'b0;
    step();
    step();
    check("rst_outs", {bus.WrEn, bus.RdEn, bus.RspValid, bus.InReady},
          32'b0001);
    check("rst_regs", {bus.WrData, bus.RspData}, 32'h0);
    check("rst_addr", 32'(bus.Address), 32'h0);
    RST = 1'b1;
    step();

    // write 0x1234 to reg 3
    send(8'hA5);
    send(8'h03);
    send(8'h34);
    send(8'h12);
    check("wr_strobe", {bus.WrEn, bus.RdEn, bus.InReady}, 32'b100);
    check("wr_addr", 32'(bus.Address), 32'd3);
    check("wr_data", 32'(bus.WrData), 32'h1234);
    step();
    check("wr_done", {bus.WrEn, bus.InReady}, 32'b01);

    // read reg 3, consumer ready
    bus.RspReady = 1'b1;
    send(8'h5A);
    send(8'h03);
    check("rd_strobe", {bus.RdEn, bus.WrEn, bus.RspValid}, 32'b100);
    step();
    check("rd_wait", {bus.RdEn, bus.RspValid, bus.InReady}, 32'b000);
    step();
    check("rsp_valid", 32'(bus.RspValid), 32'd1);
    check("rsp_data", 32'(bus.RspData), 32'h1234);
    step();
    check("rsp_once", {bus.RspValid, bus.InReady}, 32'b01);

    // read with upper address bits set, consumer stalled
    bus.RspReady = 1'b0;
    send(8'h5A);
    send(8'h0B);
    check("rd_addr_mask", 32'(bus.Address), 32'd3);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check("rsp_hold", {bus.RspValid, bus.InReady, bus.RspData},
            {14'd0, 1'b1, 1'b0, 16'h1234});
      step();
    end
    bus.RspReady = 1'b1;
    step();
    check("rsp_release", {bus.RspValid, bus.InReady}, 32'b01);

    // write with a mid-frame gap
    send(8'hA5);
    send(8'h05);
    for (int i = 0; i < 5; i++) begin
      check("gap", {bus.WrEn, bus.InReady}, 32'b01);
      step();
    end
    send(8'hCD);
    send(8'hAB);
    check("gap_wr", {bus.WrEn, bus.RdEn}, 32'b10);
    check("gap_addr", 32'(bus.Address), 32'd5);
    check("gap_data", 32'(bus.WrData), 32'hABCD);
    step();

    // reset mid data
    send(8'hA5);
    send(8'h02);
    send(8'hFF);
    RST = 1'b0;
    #1;
    check("mid_rst_outs", {bus.WrEn, bus.RdEn, bus.RspValid, bus.InReady},
          32'b0001);
    check("mid_rst_regs", {bus.WrData, bus.RspData}, 32'h0);
    check("mid_rst_addr", 32'(bus.Address), 32'h0);
    step();
    RST = 1'b1;
    step();
    send(8'h5A);
    send(8'h02);
    step();
    step();
    check("rst_rd_valid", 32'(bus.RspValid), 32'd1);
    check("rst_rd_data", 32'(bus.RspData), 32'h0000);
    step();

    // unknown command byte
    send(8'h77);
    check("unk_idle", {bus.WrEn, bus.RdEn, bus.InReady}, 32'b001);
`ifdef REG_CMD_ERR_EN
    check("cmd_err", 32'(bus.CmdErr), 32'd1);
    step();
    check("cmd_err_end", 32'(bus.CmdErr), 32'd0);
`endif
    send(8'h5A);
    send(8'h01);
    check("unk_rd", {bus.RdEn, bus.WrEn}, 32'b10);
    check("unk_rd_addr", 32'(bus.Address), 32'd1);
    step();
    step();
    check("unk_rsp", {bus.RspValid, bus.RspData}, 32'h0001_0000);
    step();

    check("wr_count", 32'(wr_cnt), 32'd2);
    check("rd_count", 32'(rd_cnt), 32'd4);
    check("excl", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
